prng_uart_tx: RTL and testbench

Serializes snapshots of the 32-bit LFSR state onto a single UART line (8N1, LSB first) so the pseudo-random stream can be captured off-chip from one output pin. The block sits directly downstream of `lfsr`: it samples `lfsr_state_o` on request, then transmits it as four bytes, least-significant byte first. The top-level wrapper drives one dedicated output pin from `tx_o` and exposes `busy_o` on a second pin.

---
 rtl/prng_pkg.sv | 29 ++
 rtl/prng_uart_tx_baud.sv | 39 +++
 rtl/prng_uart_tx.sv | 133 +++++++++++++
 tb/tb_prng_uart_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG UART transmitter.
package prng_pkg;

  localparam int unsigned PRNG_WIDTH      = 32;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned BYTES_PER_WORD  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_t;

  // Select byte idx of a captured word, byte 0 being bits 7:0.
  function automatic logic [UART_DATA_BITS-1:0] word_byte(input logic [PRNG_WIDTH-1:0] word,
                                                           input logic [1:0]            idx);
    logic [UART_DATA_BITS-1:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prng_uart_tx_baud.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 and flags the wrap cycle.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  output logic tick_o
);

  if (CLKS_PER_BIT < 2) begin : g_param_check
    $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
  end

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count_q, count_d;

  // Next count: restart on clear, wrap at the top.
  always_comb begin
    count_d = count_q + CntW'(1);
    if (clear_i || (count_q == CntMax)) begin
      count_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == CntMax);

endmodule

// File: rtl/prng_uart_tx.sv
// Captures a 32-bit LFSR snapshot and sends it LSB byte first as four 8N1 UART frames.
module prng_uart_tx
  import prng_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [PRNG_WIDTH-1:0] lfsr_state_i,
  input  logic                  start_i,
  input  logic                  cont_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [2:0] LastBit  = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

  tx_state_t                 state_q, state_d;
  logic [PRNG_WIDTH-1:0]     hold_q, hold_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [1:0]                byte_cnt_q, byte_cnt_d;
  logic                      tx_q, tx_d;
  logic                      tick;
  logic                      capture;
  logic                      done;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (capture),
    .tick_o  (tick)
  );

  // Next-state logic; tx_d is the line value for the cycle after the edge.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    capture    = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          capture = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (byte_cnt_q != LastByte) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = word_byte(hold_q, byte_cnt_q + 2'd1);
            state_d    = StStart;
            tx_d       = 1'b0;
          end else begin
            done = 1'b1;
            // start_i is only looked at here while busy, so requests are never queued.
            if (cont_i || start_i) begin
              capture = 1'b1;
            end else begin
              state_d = StIdle;
              tx_d    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    if (capture) begin
      hold_d     = lfsr_state_i;
      shift_d    = word_byte(lfsr_state_i, 2'd0);
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      state_d    = StStart;
      tx_d       = 1'b0;
    end
  end

  // State, datapath and registered line output.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = done;

endmodule

// File: tb/tb_prng_uart_tx.sv
// Self-checking bench for prng_uart_tx: scoreboarded UART receiver plus per-scenario tests.
module tb_prng_uart_tx;

  localparam int C  = 4;
  localparam int C2 = 2;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] lfsr_state_i = '0;
  logic        start_i = 1'b0;
  logic        cont_i = 1'b0;
  logic        tx_o, busy_o, done_o;

  logic [31:0] lfsr2 = '0;
  logic        start2 = 1'b0;
  logic        cont2 = 1'b0;
  logic        tx2, busy2, done2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         byte_start_q[$];
  int         done_q[$];

  prng_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lfsr_state_i (lfsr_state_i),
    .start_i      (start_i),
    .cont_i       (cont_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  prng_uart_tx #(.CLKS_PER_BIT(C2)) dut2 (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .lfsr_state_i (lfsr2),
    .start_i      (start2),
    .cont_i       (cont2),
    .tx_o         (tx2),
    .busy_o       (busy2),
    .done_o       (done2)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every done pulse cycle.
  always @(negedge clk_i) if (done_o === 1'b1) done_q.push_back(cyc);

  // UART receiver: samples each bit mid-way and scores the byte against the expected queue.
  always begin : rx_mon
    logic [9:0] bits;
    logic [7:0] exp_b;
    bit         abort;
    int         s;
    @(negedge clk_i);
    if (!reset_i && tx_o === 1'b0) begin
      s = cyc;
      abort = 1'b0;
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? C / 2 : C) @(negedge clk_i);
        if (reset_i) abort = 1'b1;
        bits[k] = tx_o;
      end
      if (!abort) begin
        byte_start_q.push_back(s);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got frame %b at cycle %0d, expected no frame", bits, s);
        end else begin
          exp_b = exp_q.pop_front();
          if (bits !== {1'b1, exp_b, 1'b0}) begin
            errors++;
            $display("FAIL rx_byte: got frame %b, expected %b", bits, {1'b1, exp_b, 1'b0});
          end
        end
      end
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    byte_start_q.delete();
    done_q.delete();
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // One-cycle start pulse; e is the capture cycle as seen at its negedge.
  task automatic start_word(input logic [31:0] w, output int e);
    @(negedge clk_i);
    lfsr_state_i = w;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    e = cyc;
  endtask

  task automatic test_reset();
    int  e;
    bit  quiet;
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", tx_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_o); end
    @(negedge clk_i);
    reset_i = 1'b0;
    clear_sb();
    start_word(32'hDEADBEEF, e);
    repeat (2 * C + 2) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, expected 1", busy_o); end
    #1 reset_i = 1'b1;
    #1;
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b, expected 1", tx_o); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL abort_done: got %b, expected 0", done_o); end
    repeat (3 * C) @(negedge clk_i);
    reset_i = 1'b0;
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL post_reset_idle: got activity, expected idle line"); end
    checks++;
    if (byte_start_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_frames: got %0d bytes %0d dones, expected 0 0",
               byte_start_q.size(), done_q.size());
    end
  endtask

  task automatic test_single_word();
    int         e;
    logic [9:0] got;
    logic [9:0] want;
    clear_sb();
    want = 10'b1011110000;
    start_word(32'h12345678, e);
    push_word(32'h12345678);
    repeat (C / 2) @(negedge clk_i);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (C) @(negedge clk_i);
      got[k] = tx_o;
    end
    checks++;
    if (got !== want) begin errors++; $display("FAIL first_frame: got %b, expected %b", got, want); end
    for (int i = 0; i < 200 && done_q.size() == 0; i++) @(negedge clk_i);
    repeat (5) @(negedge clk_i);
    checks++;
    if (done_q.size() != 1) begin
      errors++;
      $display("FAIL done_count: got %0d pulses, expected 1", done_q.size());
    end else if (done_q[0] != e + 159) begin
      errors++;
      $display("FAIL done_cycle: got %0d, expected %0d", done_q[0] - e, 159);
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_after: got %b, expected 0", busy_o); end
    checks++;
    if (exp_q.size() != 0 || byte_start_q.size() != 4) begin
      errors++;
      $display("FAIL single_bytes: got %0d received %0d pending, expected 4 0",
               byte_start_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (byte_start_q[k] != e + 10 * C * k) begin
          errors++;
          $display("FAIL byte_start: got %0d, expected %0d", byte_start_q[k] - e, 10 * C * k);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int e;
    clear_sb();
    start_word(32'hCAFEF00D, e);
    push_word(32'hCAFEF00D);
    repeat (170) begin
      @(negedge clk_i);
      lfsr_state_i = $urandom;
    end
    checks++;
    if (exp_q.size() != 0 || byte_start_q.size() != 4 || done_q.size() != 1) begin
      errors++;
      $display("FAIL snapshot: got %0d bytes %0d pending %0d dones, expected 4 0 1",
               byte_start_q.size(), exp_q.size(), done_q.size());
    end
  endtask

  task automatic test_start_held();
    int e;
    bit gap;
    clear_sb();
    gap = 1'b0;
    @(negedge clk_i);
    lfsr_state_i = 32'hFFFF0000;
    start_i = 1'b1;
    @(negedge clk_i);
    e = cyc;
    push_word(32'hFFFF0000);
    push_word(32'h0F0F1234);
    lfsr_state_i = 32'h0F0F1234;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b1) gap = 1'b1;
    end
    start_i = 1'b0;
    for (int i = 0; i < 300 && done_q.size() < 2; i++) begin
      @(negedge clk_i);
      if (cyc <= e + 319 && busy_o !== 1'b1) gap = 1'b1;
    end
    repeat (100) @(negedge clk_i);
    checks++;
    if (gap) begin errors++; $display("FAIL held_busy: got busy low mid-run, expected 1"); end
    checks++;
    if (done_q.size() != 2) begin
      errors++;
      $display("FAIL held_dones: got %0d, expected 2", done_q.size());
    end else if (done_q[0] != e + 159 || done_q[1] != e + 319) begin
      errors++;
      $display("FAIL held_done_cycles: got %0d %0d, expected 159 319", done_q[0] - e, done_q[1] - e);
    end
    checks++;
    if (byte_start_q.size() != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_bytes: got %0d received %0d pending, expected 8 0",
               byte_start_q.size(), exp_q.size());
    end else if (byte_start_q[4] != e + 160) begin
      errors++;
      $display("FAIL held_gap: got second word at %0d, expected 160", byte_start_q[4] - e);
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL held_idle: got busy %b, expected 0", busy_o); end
  endtask

  task automatic test_continuous();
    int e;
    bit gap;
    clear_sb();
    gap = 1'b0;
    cont_i = 1'b1;
    start_word(32'h0BADF00D, e);
    push_word(32'h0BADF00D);
    push_word(32'h13579BDF);
    lfsr_state_i = 32'h13579BDF;
    while (cyc < e + 160) begin
      @(negedge clk_i);
      if (busy_o !== 1'b1) gap = 1'b1;
    end
    checks++;
    if (tx_o !== 1'b0) begin errors++; $display("FAIL cont_start_bit: got %b, expected 0", tx_o); end
    repeat (40) begin
      @(negedge clk_i);
      if (busy_o !== 1'b1) gap = 1'b1;
    end
    cont_i = 1'b0;
    for (int i = 0; i < 300 && done_q.size() < 2; i++) begin
      @(negedge clk_i);
      if (cyc <= e + 319 && busy_o !== 1'b1) gap = 1'b1;
    end
    repeat (20) @(negedge clk_i);
    checks++;
    if (gap) begin errors++; $display("FAIL cont_busy: got busy low mid-run, expected 1"); end
    checks++;
    if (done_q.size() != 2) begin
      errors++;
      $display("FAIL cont_dones: got %0d, expected 2", done_q.size());
    end else if (done_q[1] - done_q[0] != 160 || done_q[0] != e + 159) begin
      errors++;
      $display("FAIL cont_done_cycles: got %0d %0d, expected 159 319", done_q[0] - e, done_q[1] - e);
    end
    checks++;
    if (byte_start_q.size() != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL cont_bytes: got %0d received %0d pending, expected 8 0",
               byte_start_q.size(), exp_q.size());
    end
  endtask

  task automatic test_boundary();
    logic [7:0] q2[$];
    logic [7:0] b;
    logic [9:0] f;
    @(negedge clk_i);
    lfsr2 = 32'hA5A5A5A5;
    start2 = 1'b1;
    @(negedge clk_i);
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) q2.push_back(8'hA5);
    @(negedge clk_i);
    for (int bi = 0; bi < 4; bi++) begin
      for (int k = 0; k < 10; k++) begin
        if (bi != 0 || k != 0) repeat (C2) @(negedge clk_i);
        f[k] = tx2;
      end
      b = q2.pop_front();
      checks++;
      if (f !== {1'b1, b, 1'b0}) begin
        errors++;
        $display("FAIL fast_frame: got %b, expected %b", f, {1'b1, b, 1'b0});
      end
    end
    checks++;
    if (done2 !== 1'b1) begin errors++; $display("FAIL fast_done: got %b, expected 1", done2); end
    @(negedge clk_i);
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL fast_idle: got busy %b done %b, expected 0 0", busy2, done2);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    test_reset();
    test_single_word();
    test_snapshot();
    test_start_held();
    test_continuous();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
